// File: rtl/music_pkg.sv
// Shared definitions for the song sequencer: ROM entry layout, special codes and FSM states.
package music_pkg;

   localparam logic [7:0] END_CODE  = 8'hFF;
   localparam logic [5:0] REST_CODE = 6'd0;

   localparam int unsigned NOTE_LSB = 0;
   localparam int unsigned NOTE_MSB = 5;
   localparam int unsigned LEN_LSB  = 6;
   localparam int unsigned LEN_MSB  = 7;

   typedef enum logic [2:0] {
      StIdle,
      StFetch,
      StLatch,
      StPlay,
      StGap,
      StHalt
   } seq_state_t;

endpackage

// File: rtl/note_timer.sv
// Loadable 32-bit down-counter timing both the sounding part and the trailing gap of a note.
module note_timer (
   input  logic        clk,
   input  logic        rst,
   input  logic        i_clear,
   input  logic        i_load,
   input  logic [31:0] i_load_val,
   input  logic        i_dec,
   output logic        o_zero
);

   logic [31:0] r_count;

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         r_count <= '0;
      end else if (i_clear) begin
         r_count <= '0;
      end else if (i_load) begin
         r_count <= i_load_val;
      end else if (i_dec && (r_count != '0)) begin
         r_count <= r_count - 32'd1;
      end
   end

   assign o_zero = (r_count == '0);

endmodule

// File: rtl/note_sequencer.sv
// Walks a registered song ROM, holding each note for (L+1) beats with a trailing articulation gap.
module note_sequencer
   import music_pkg::*;
#(
   parameter int unsigned BEAT_CYCLES = 8388608,
   parameter int unsigned GAP_CYCLES  = 262144,
   parameter int unsigned ADDR_W      = 8
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              play,
   input  logic              rewind,
   output logic [ADDR_W-1:0] rom_addr,
   input  logic [7:0]        rom_data,
   output logic [7:0]        note,
   output logic              note_strobe,
   output logic              playing,
   output logic              song_end
);

   seq_state_t        r_state, w_state;
   logic [ADDR_W-1:0] r_addr, w_addr;
   logic [7:0]        r_note, w_note;
   logic              r_strobe, w_strobe;
   logic              r_song_end, w_song_end;
   logic              r_playing, w_playing;

   logic        w_clear, w_load, w_dec, w_zero, w_running;
   logic [31:0] w_load_val, w_play_load;
   logic [1:0]  w_len;

   assign w_len = rom_data[LEN_MSB:LEN_LSB];
   // Sounding portion excludes the gap; the -1 accounts for the terminal zero cycle.
   assign w_play_load = ({30'd0, w_len} + 32'd1) * 32'(BEAT_CYCLES)
                        - 32'(GAP_CYCLES) - 32'd1;

   assign w_running = (r_state == StFetch) || (r_state == StLatch) ||
                      (r_state == StPlay)  || (r_state == StGap);

   note_timer u_timer (
      .clk        (clk),
      .rst        (rst),
      .i_clear    (w_clear),
      .i_load     (w_load),
      .i_load_val (w_load_val),
      .i_dec      (w_dec),
      .o_zero     (w_zero)
   );

   always_comb begin
      w_state    = r_state;
      w_addr     = r_addr;
      w_note     = r_note;
      w_strobe   = 1'b0;
      w_song_end = 1'b0;
      w_clear    = 1'b0;
      w_load     = 1'b0;
      w_load_val = w_play_load;
      w_dec      = 1'b0;

      if (rewind) begin
         w_addr  = '0;
         w_clear = 1'b1;
         w_note  = {2'b00, REST_CODE};
         w_state = play ? StFetch : StIdle;
      end else if (w_running && !play) begin
         w_state = StIdle;
         w_clear = 1'b1;
         w_note  = {2'b00, REST_CODE};
      end else begin
         unique case (r_state)
            StIdle: begin
               w_note = {2'b00, REST_CODE};
               if (play) w_state = StFetch;
            end
            StFetch: w_state = StLatch;
            StLatch: begin
               if (rom_data == END_CODE) begin
                  w_song_end = 1'b1;
                  w_addr     = '0;
                  w_state    = (r_addr == '0) ? StHalt : StFetch;
               end else begin
                  w_note   = {2'b00, rom_data[NOTE_MSB:NOTE_LSB]};
                  w_strobe = 1'b1;
                  w_load   = 1'b1;
                  w_state  = StPlay;
               end
            end
            StPlay: begin
               if (!w_zero) begin
                  w_dec = 1'b1;
               end else if (GAP_CYCLES == 0) begin
                  w_addr  = r_addr + 1'b1;
                  w_state = StFetch;
               end else begin
                  w_note     = {2'b00, REST_CODE};
                  w_load     = 1'b1;
                  w_load_val = 32'(GAP_CYCLES) - 32'd1;
                  w_state    = StGap;
               end
            end
            StGap: begin
               if (!w_zero) begin
                  w_dec = 1'b1;
               end else begin
                  w_addr  = r_addr + 1'b1;
                  w_state = StFetch;
               end
            end
            StHalt: begin
               w_note = {2'b00, REST_CODE};
               if (!play) w_state = StIdle;
            end
            default: w_state = StIdle;
         endcase
      end

      w_playing = (w_state == StFetch) || (w_state == StLatch) ||
                  (w_state == StPlay)  || (w_state == StGap);
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         r_state    <= StIdle;
         r_addr     <= '0;
         r_note     <= '0;
         r_strobe   <= 1'b0;
         r_song_end <= 1'b0;
         r_playing  <= 1'b0;
      end else begin
         r_state    <= w_state;
         r_addr     <= w_addr;
         r_note     <= w_note;
         r_strobe   <= w_strobe;
         r_song_end <= w_song_end;
         r_playing  <= w_playing;
      end
   end

   assign rom_addr    = r_addr;
   assign note        = r_note;
   assign note_strobe = r_strobe;
   assign playing     = r_playing;
   assign song_end    = r_song_end;

endmodule

// File: doc/note_sequencer.md
Name: note_sequencer

Overview:
Tempo and sequencing stage that sits directly upstream of the tone generator. It walks a synchronous song ROM and holds each note code for a per-entry duration. It inserts a short articulation rest so repeated notes stay distinct. Its note output uses the tone generator's full-note format: 0 = rest, otherwise octave*12 + semitone, 6 significant bits. It replaces the free-running tone-counter address scheme.

Parameters:
BEAT_CYCLES, 8388608, clk cycles per beat (2^23, same tempo as the existing address counter)
GAP_CYCLES, 262144, trailing silent cycles inside every note; must be < BEAT_CYCLES; 0 disables the gap
ADDR_W, 8, song ROM address width

Ports:
clk  input  1  system clock (25 MHz divided clock domain)
rst  input  1  asynchronous, active-high reset
play  input  1  level; 1 = run, 0 = pause
rewind  input  1  single-cycle pulse; return to entry 0
rom_addr  output  ADDR_W  song ROM address
rom_data  input  8  ROM entry; registered ROM, valid one clk after rom_addr
note  output  8  full-note code to the tone generator; [7:6] always 0
note_strobe  output  1  one-cycle pulse on each newly loaded entry, rests included
playing  output  1  high in FETCH/LATCH/PLAY/GAP
song_end  output  1  one-cycle pulse when the end marker is read

Behaviour:
- Entry format: [5:0] note code; [7:6] length L, so the note lasts (L+1) beats. 8'hFF is the end marker. 8'h00 (and any code 0) is a rest.
- Reset: state IDLE, rom_addr=0, note=0, note_strobe=0, playing=0, song_end=0, duration counter=0. All outputs are registered.
- States: IDLE, FETCH, LATCH, PLAY, GAP, HALT.
- IDLE: note=0. If play=1, go to FETCH. rom_addr is retained, so pause resumes at the start of the interrupted entry.
- FETCH: one wait cycle while the ROM registers rom_addr. Go to LATCH.
- LATCH, data = end marker:
  - pulse song_end; set rom_addr=0.
  - if the current rom_addr was already 0 (empty song), go to HALT; otherwise go to FETCH.
- LATCH, data ≠ end marker:
  - note <= {2'b0, data[5:0]}; pulse note_strobe.
  - counter <= (L+1)*BEAT_CYCLES − GAP_CYCLES − 1; go to PLAY.
- Latency: play sampled high at edge E0 → FETCH; E1 → LATCH; E2 → note valid with note_strobe.
- PLAY: decrement the counter each cycle. At 0:
  - GAP_CYCLES=0: rom_addr++ and go to FETCH.
  - otherwise: note <= 0, counter <= GAP_CYCLES−1, go to GAP.
- GAP: at counter 0, rom_addr++ and go to FETCH. rom_addr wraps from 2^ADDR_W−1 to 0 with no song_end.
- Entry period: LATCH-to-LATCH = (L+1)*BEAT_CYCLES + 2 cycles (2 = fetch overhead).
- HALT: playing=0, note=0. Stay until play=0, then go to IDLE.
- play=0 in any running state: at the next edge go to IDLE; note=0; counter cleared.
- rewind, applied at the next edge:
  - rom_addr=0, counter cleared, note=0.
  - then FETCH if play=1, else IDLE.
  - rewind has priority over all other transitions, including an end marker in LATCH.
- Reset asserted mid-operation forces the reset values immediately (asynchronous).
- Counter is 32 bits unsigned. The product (L+1)*BEAT_CYCLES is computed at full 32-bit width; parameters must keep 4*BEAT_CYCLES < 2^32.

Decomposition:
- Shared package music_pkg holds:
  - END_CODE = 8'hFF, REST_CODE = 6'd0
  - field positions NOTE_LSB/NOTE_MSB and LEN_LSB/LEN_MSB
  - the state enum typedef seq_state_t
- One sub-module, note_timer: a loadable 32-bit down-counter with a load value, load strobe, clear and zero flag, used for both PLAY and GAP.

Test Plan:
All cases use BEAT_CYCLES=8 and GAP_CYCLES=2.
1. ROM {0x1B, 0x5D, 0xFF}, play=1:
   - note=27 for 6 cycles, then 0 for 2, then 2 overhead cycles.
   - note=29 for 14 cycles, then 0 for 2.
   - song_end pulses once, then note=27 again; note_strobe pulses exactly 2× per loop.
2. Entry 0x40 (rest, L=1) → note_strobe pulses, note stays 0 for 16 cycles, then rom_addr advances by 1.
3. Deassert play 3 cycles into note 27:
   - next cycle note=0 and playing=0.
   - reassert play → note=27 reloads 2 edges later with a full 6-cycle hold; rom_addr unchanged.
4. rewind pulse during entry 1 → rom_addr=0, note=0; 2 edges later note=27 with note_strobe.
5. rst pulse mid-PLAY → note=0, rom_addr=0, playing=0 immediately; after release and play=1, sequence restarts at entry 0.
6. ROM[0]=0xFF, play=1:
   - song_end pulses once, HALT entered, no note_strobe, playing=0 while play is held.
   - drop play, then reassert → repeats exactly once.
